// File: rtl/wts_channel_mixer_if.sv
// Wave SRAM read port between the channel mixer and the sample store.
// Master issues address/strobe, slave returns the signed sample.
interface wts_channel_mixer_if;
  logic [9:0] sram_a;
  logic       sram_rd;
  logic [7:0] sram_q;

  modport master (
    output sram_a,
    output sram_rd,
    input  sram_q
  );

  modport slave (
    input  sram_a,
    input  sram_rd,
    output sram_q
  );
endinterface

// File: rtl/wts_channel_mixer.sv
// Wavetable channel mixer: per-frame shadow latch, serial SRAM reads, MAC, >>>5 out.
// Optional per-channel mask input enabled by WTS_CHANNEL_MIXER_MASK_EN.
module wts_channel_mixer #(
  parameter int CH_NUM       = 6,
  parameter int SRAM_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  nreset,
  input  logic                  active,
  input  logic [7*CH_NUM-1:0]   wave_a,
  input  logic [9*CH_NUM-1:0]   envelope,
`ifdef WTS_CHANNEL_MIXER_MASK_EN
  input  logic [CH_NUM-1:0]     reg_channel_mask,
`endif
  wts_channel_mixer_if.master   bus,
  output logic [15:0]           sound_out,
  output logic                  sound_valid,
  output logic                  overrun
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WAIT,
    DONE
  } state_t;

  localparam logic [2:0] LAST  = 3'(CH_NUM - 1);
  localparam logic [1:0] WLOAD = 2'(SRAM_LATENCY - 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [2:0]         r_ch;
  logic [2:0]         w_ch_nxt;
  logic [2:0]         w_ch_inc;
  logic [1:0]         r_wait;
  logic signed [20:0] r_acc;
  logic signed [20:0] w_acc_sum;
  logic signed [17:0] w_prod;
  logic [9:0]         r_sram_a;
  logic               r_sram_rd;
  logic [15:0]        r_sound_out;
  logic               r_sound_valid;
  logic               r_overrun;

  logic [6:0]         r_sh_a   [CH_NUM];
  logic [8:0]         r_sh_env [CH_NUM];
  logic [CH_NUM-1:0]  w_m_sh;
  logic [CH_NUM-1:0]  w_m_in;

  logic               w_start;
  logic               w_issue;
  logic               w_adv;
  logic               w_acc_en;
  logic               w_fin;
  logic               w_iss_m;
  logic [6:0]         w_iss_a;

`ifdef WTS_CHANNEL_MIXER_MASK_EN
  logic [CH_NUM-1:0]  r_sh_m;

  // Mask is part of the frame snapshot
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) r_sh_m <= '0;
    else if (w_start) r_sh_m <= reg_channel_mask;
  end

  assign w_m_sh = r_sh_m;
  assign w_m_in = reg_channel_mask;
`else
  assign w_m_sh = '0;
  assign w_m_in = '0;
`endif

  assign w_ch_inc = r_ch + 3'd1;
  assign w_prod   = $signed(bus.sram_q)
                  * $signed({1'b0, r_sh_env[r_ch]});
  assign w_acc_sum = w_acc_en
                   ? r_acc + {{3{w_prod[17]}}, w_prod}
                   : r_acc;

  // Next state and per-cycle control strobes
  always_comb begin
    w_state_nxt = r_state;
    w_ch_nxt    = r_ch;
    w_start     = 1'b0;
    w_issue     = 1'b0;
    w_adv       = 1'b0;
    w_acc_en    = 1'b0;
    w_fin       = 1'b0;
    w_iss_m     = 1'b0;
    w_iss_a     = r_sh_a[r_ch];
    unique case (r_state)
      IDLE: begin
        if (active) begin
          w_start     = 1'b1;
          w_issue     = 1'b1;
          w_ch_nxt    = 3'd0;
          w_iss_a     = wave_a[6:0];
          w_iss_m     = w_m_in[0];
          w_state_nxt = READ;
        end
      end
      READ: begin
        if (w_m_sh[r_ch]) w_adv = 1'b1;
        else w_state_nxt = WAIT;
      end
      WAIT: begin
        if (r_wait == 2'd0) begin
          w_adv    = 1'b1;
          w_acc_en = 1'b1;
        end
      end
      DONE: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
    if (w_adv) begin
      if (r_ch == LAST) begin
        w_fin       = 1'b1;
        w_state_nxt = DONE;
      end else begin
        w_issue     = 1'b1;
        w_ch_nxt    = w_ch_inc;
        w_iss_a     = r_sh_a[w_ch_inc];
        w_iss_m     = w_m_sh[w_ch_inc];
        w_state_nxt = READ;
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) r_state <= IDLE;
    else r_state <= w_state_nxt;
  end

  // Frame snapshot of addresses and envelopes
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      for (int i = 0; i < CH_NUM; i++) begin
        r_sh_a[i]   <= '0;
        r_sh_env[i] <= '0;
      end
    end else if (w_start) begin
      for (int i = 0; i < CH_NUM; i++) begin
        r_sh_a[i]   <= wave_a[7*i +: 7];
        r_sh_env[i] <= envelope[9*i +: 9];
      end
    end
  end

  // Channel walk, SRAM strobe, accumulator and output
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_ch          <= '0;
      r_wait        <= '0;
      r_acc         <= '0;
      r_sram_a      <= '0;
      r_sram_rd     <= 1'b0;
      r_sound_out   <= '0;
      r_sound_valid <= 1'b0;
      r_overrun     <= 1'b0;
    end else begin
      r_ch      <= w_ch_nxt;
      r_sram_rd <= w_issue & ~w_iss_m;
      if (w_issue & ~w_iss_m) r_sram_a <= {w_ch_nxt, w_iss_a};
      if (r_state == READ) r_wait <= WLOAD;
      else if (r_state == WAIT && r_wait != 2'd0)
        r_wait <= r_wait - 2'd1;
      if (w_start) r_acc <= '0;
      else if (w_acc_en) r_acc <= w_acc_sum;
      if (w_fin) r_sound_out <= w_acc_sum[20:5];
      r_sound_valid <= w_fin;
      if (active && r_state != IDLE) r_overrun <= 1'b1;
    end
  end

  assign bus.sram_a  = r_sram_a;
  assign bus.sram_rd = r_sram_rd;
  assign sound_out   = r_sound_out;
  assign sound_valid = r_sound_valid;
  assign overrun     = r_overrun;

endmodule

// File: tb/tb_wts_channel_mixer.sv
// Bench for wts_channel_mixer: SRAM model, frame-level reference model.
// Directed spec cases plus randomized frames.
module tb_wts_channel_mixer;
  localparam int CH = 6;
  localparam int L  = 1;

  logic            clk;
  logic            nreset;
  logic            active;
  logic [7*CH-1:0] wave_a;
  logic [9*CH-1:0] envelope;
  logic [15:0]     sound_out;
  logic            sound_valid;
  logic            overrun;
`ifdef WTS_CHANNEL_MIXER_MASK_EN
  logic [CH-1:0]   reg_channel_mask;
`endif

  wts_channel_mixer_if bus();

  wts_channel_mixer #(.CH_NUM(CH), .SRAM_LATENCY(L)) dut (
    .clk(clk),
    .nreset(nreset),
    .active(active),
    .wave_a(wave_a),
    .envelope(envelope),
`ifdef WTS_CHANNEL_MIXER_MASK_EN
    .reg_channel_mask(reg_channel_mask),
`endif
    .bus(bus),
    .sound_out(sound_out),
    .sound_valid(sound_valid),
    .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] mem  [1024];
  logic [7:0] pipe [L];

  always @(posedge clk) begin
    if (bus.sram_rd) pipe[0] <= mem[bus.sram_a];
    for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
  end
  assign bus.sram_q = pipe[L-1];

  int total = 0;
  int bad   = 0;
  int last_out;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [CH-1:0] cur_mask();
`ifdef WTS_CHANNEL_MIXER_MASK_EN
    return reg_channel_mask;
`else
    return '0;
`endif
  endfunction

  task automatic set_ch(input int ch, input int wa, input int env);
    wave_a[7*ch +: 7]   = 7'(wa);
    envelope[9*ch +: 9] = 9'(env);
  endtask

  task automatic frame(input string tag, input int second_at,
                       input bit perturb, input int rst_at);
    int          exp_sum;
    int          exp_cyc;
    int          vcnt;
    int          vcyc;
    int          s;
    int          e;
    logic [9:0]  a;
    logic [9:0]  exp_a[$];
    logic [9:0]  got_a[$];
    logic [CH-1:0] m;
    m       = cur_mask();
    exp_sum = 0;
    exp_cyc = 1;
    vcnt    = 0;
    vcyc    = -1;
    for (int ch = 0; ch < CH; ch++) begin
      if (m[ch]) begin
        exp_cyc += 1;
      end else begin
        a = {3'(ch), wave_a[7*ch +: 7]};
        exp_a.push_back(a);
        s = $signed(mem[a]);
        e = int'(envelope[9*ch +: 9]);
        exp_sum += s * e;
        exp_cyc += 1 + L;
      end
    end
    @(negedge clk);
    active = 1'b1;
    @(negedge clk);
    active = 1'b0;
    if (perturb) begin
      wave_a   = {$urandom, $urandom};
      envelope = {$urandom, $urandom};
    end
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (bus.sram_rd) got_a.push_back(bus.sram_a);
      if (sound_valid) begin
        vcnt++;
        vcyc     = cyc;
        last_out = $signed(sound_out);
      end
      if (cyc == second_at) active = 1'b1;
      if (cyc == second_at + 1) active = 1'b0;
      if (cyc == rst_at) nreset = 1'b0;
      if (cyc == rst_at + 2) nreset = 1'b1;
      @(negedge clk);
    end
    if (rst_at > 0) begin
      chk({tag, "_nvalid"}, vcnt, 0);
      chk({tag, "_out0"}, $signed(sound_out), 0);
    end else begin
      chk({tag, "_nvalid"}, vcnt, 1);
      chk({tag, "_vcyc"}, vcyc, exp_cyc);
      chk({tag, "_out"}, last_out, exp_sum >>> 5);
      chk({tag, "_nrd"}, got_a.size(), exp_a.size());
      for (int i = 0; i < exp_a.size(); i++) begin
        if (i < got_a.size())
          chk({tag, "_addr"}, int'(got_a[i]), int'(exp_a[i]));
      end
    end
  endtask

  task automatic rand_setup();
    wave_a   = {$urandom, $urandom};
    envelope = {$urandom, $urandom};
    for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
  endtask

  initial begin
    int rd_seen;
    int v_seen;
    nreset   = 1'b0;
    active   = 1'b0;
    wave_a   = '0;
    envelope = '0;
`ifdef WTS_CHANNEL_MIXER_MASK_EN
    reg_channel_mask = '0;
`endif
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    for (int i = 0; i < L; i++) pipe[i] = 8'h00;
    #23;
    chk("rst_out", $signed(sound_out), 0);
    chk("rst_valid", sound_valid, 0);
    chk("rst_rd", bus.sram_rd, 0);
    chk("rst_a", bus.sram_a, 0);
    nreset = 1'b1;
    rd_seen = 0;
    v_seen  = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      rd_seen += bus.sram_rd;
      v_seen  += sound_valid;
    end
    chk("idle_rd", rd_seen, 0);
    chk("idle_valid", v_seen, 0);
    chk("idle_out", $signed(sound_out), 0);
    chk("idle_ovr", overrun, 0);

    rand_setup();
    frame("rstmid", 0, 0, 6);
    chk("rstmid_ovr", overrun, 0);
    frame("after_rst", 0, 0, 0);

    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    for (int ch = 0; ch < CH; ch++)
      set_ch(ch, $urandom_range(0, 127), ch == 0 ? 256 : $urandom_range(0, 511));
    mem[{3'd0, wave_a[6:0]}] = 8'd127;
    frame("fullscale", 0, 0, 0);
    chk("fullscale_lit", last_out, 1016);

    for (int ch = 0; ch < CH; ch++) set_ch(ch, 5 + ch, 0);
    set_ch(0, 5, 511);
    set_ch(1, 6, 100);
    mem[{3'd0, 7'd5}] = 8'h80;
    mem[{3'd1, 7'd6}] = 8'd64;
    frame("mixed", 0, 0, 0);
    chk("mixed_lit", last_out, -1844);

    for (int ch = 0; ch < CH; ch++) set_ch(ch, ch, 511);
    for (int ch = 0; ch < CH; ch++) mem[{3'(ch), 7'(ch)}] = 8'h80;
    frame("minfull", 0, 0, 0);

    rand_setup();
    frame("coher", 0, 1, 0);

    for (int k = 0; k < 6; k++) begin
      rand_setup();
      frame("rand", 0, 0, 0);
    end
    chk("noovr", overrun, 0);

`ifdef WTS_CHANNEL_MIXER_MASK_EN
    rand_setup();
    reg_channel_mask = 6'b000010;
    set_ch(1, 9, 511);
    mem[{3'd1, 7'd9}] = 8'd127;
    frame("mask", 0, 0, 0);
    reg_channel_mask = '0;
`endif

    rand_setup();
    frame("ovr", 5, 0, 0);
    chk("ovr_set", overrun, 1);
    repeat (10) @(negedge clk);
    chk("ovr_sticky", overrun, 1);
    rand_setup();
    frame("post_ovr", 0, 0, 0);
    chk("ovr_sticky2", overrun, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=0 exp=1");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/wts_channel_mixer.md
Name: wts_channel_mixer

Overview:
- Consumer end of the per-channel wave address / envelope interface.
- Once per `active` pulse, latches every channel's 7-bit wave address and 9-bit envelope.
- Reads each channel's signed 8-bit sample from wave SRAM, one channel at a time.
- Multiplies each sample by its envelope, sums all channels, and presents one signed 16-bit mixed sample with a valid pulse.

Parameters:
- CH_NUM, 6, number of channels mixed; legal range 1..8.
- SRAM_LATENCY, 1, clocks from `sram_rd` to valid `sram_q`; legal range 1..3.

Ports:
- clk  input  1  system clock
- nreset  input  1  asynchronous active-low reset
- active  input  1  frame start pulse, 3.579MHz timing
- wave_a  input  7*CH_NUM  channel i address at [7i+6:7i]
- envelope  input  9*CH_NUM  channel i envelope at [9i+8:9i], unsigned 0..511
- sram_a  output  10  {channel index[2:0], wave address[6:0]}
- sram_rd  output  1  one-cycle read strobe
- sram_q  input  8  signed two's-complement sample
- sound_out  output  16  signed mixed sample, held between updates
- sound_valid  output  1  one-cycle pulse when `sound_out` updates
- overrun  output  1  sticky: an `active` pulse arrived while busy

Behaviour:
- Clock/reset: one clock, `clk`; reset `nreset` is asynchronous, active-low.
- Reset values: state=IDLE; `sram_a`=0; `sram_rd`=0; `sound_out`=0; `sound_valid`=0; `overrun`=0; accumulator=0; channel counter=0; wait counter=0.
- FSM states: IDLE, READ, WAIT, DONE.
- IDLE: on `active`=1, latch all of `wave_a` and `envelope` into shadow registers, clear accumulator, set ch=0, go to READ.
  - Shadow latching makes the frame coherent even if inputs change mid-frame.
- READ (1 cycle):
  - Drive `sram_a`={ch[2:0], shadow_a[ch]} and `sram_rd`=1.
  - Load wait counter with SRAM_LATENCY-1.
  - Go to WAIT.
- WAIT:
  - `sram_rd`=0, `sram_a` held.
  - When wait counter=0, `sram_q` is valid: accumulator += $signed(sram_q) * $signed({1'b0, shadow_env[ch]}).
    - Product is 18-bit signed; accumulator is 21-bit signed.
  - If ch=CH_NUM-1 go to DONE, else ch+=1 and go to READ.
  - Otherwise decrement the wait counter.
- DONE (1 cycle): `sound_out` <= accumulator[20:5] (arithmetic >>5); `sound_valid`=1; go to IDLE.
- Output range:
  - Max |acc| = 128*511*8 = 523264, which fits 21 bits signed.
  - acc>>>5 always fits 16 bits, so no saturation logic.
- Latency:
  - `active` sampled at edge 0; first `sram_rd` at cycle 1.
  - `sound_valid` at cycle 1 + CH_NUM*(1+SRAM_LATENCY).
  - Defaults: CH_NUM=6, SRAM_LATENCY=1 gives `sound_valid` 13 cycles after `active`.
- `active` while state≠IDLE:
  - Pulse ignored; frame in progress completes unchanged.
  - `overrun` set to 1, cleared only by reset.
- `active` coincident with DONE: ignored and flags `overrun`; the next pulse in IDLE is accepted.
- Envelope 0: read still issued; contribution 0.
- Envelope 511 with sample -128: product -65408, handled with no wrap.
- Reset mid-frame: everything returns to reset values immediately; partial sum discarded; no `sound_valid`.

Optional Feature:
- Macro: WTS_CHANNEL_MIXER_MASK_EN.
- With the macro defined:
  - Extra input `reg_channel_mask` [CH_NUM-1:0], latched at frame start with the other shadows.
  - A masked channel (bit=1) skips READ/WAIT entirely: no `sram_rd`, zero contribution, ch advances in one cycle.
  - Frame latency shrinks by SRAM_LATENCY per masked channel.
- Without the macro: port absent; all channels always read and mixed.

Test Plan:
- Reset then idle: `nreset` low, then high, no `active` -> `sound_out`=0, `sound_valid`=0, `sram_rd`=0, `overrun`=0 indefinitely.
- Single-channel full scale:
  - Stimulus: CH_NUM=6, ch0 env=256, sram model returns 127 for ch0 and 0 elsewhere; pulse `active`.
  - Required: 6 `sram_rd` pulses with `sram_a`[9:7]=0..5; `sound_valid` at cycle 13; `sound_out`=32512>>5=1016.
- Mixed signs:
  - Stimulus: ch0 sample=-128 env=511, ch1 sample=64 env=100, others env 0.
  - Required: acc=-65408+6400=-59008; `sound_out`=-1844.
- Coherence: change `wave_a`/`envelope` on the cycle after `active` -> `sram_a` addresses and result reflect the values latched at `active`.
- Overrun: second `active` 5 cycles after the first -> first frame result correct, exactly one `sound_valid`, `overrun`=1 and stays 1.
- Reset mid-frame: assert `nreset` at cycle 6 -> no `sound_valid`; `sound_out` stays 0; next frame after release produces the correct sum.
- Mask (macro on):
  - Stimulus: `reg_channel_mask`=6'b000010, ch1 sample=127 env=511.
  - Required: no read with `sram_a`[9:7]=1; ch1 contributes 0; `sound_valid` 1 cycle earlier than unmasked.
